config_frame_loader: RTL and testbench
======================================

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

Interface
REQ-001 SHALL have parameter FRAME_BITS_PER_ROW, default 32, width of config words and frame data.
REQ-002 SHALL have parameter NUMBER_OF_ROWS, default 16, data words per frame (1..2^ROW_SELECT_WIDTH-1).
REQ-003 SHALL have parameter ROW_SELECT_WIDTH, default 5, width of RowSelect.
REQ-004 SHALL have parameter SYNC_WORD, default 32'hFAB0_FAB1, word that enters synchronised mode.
REQ-005 SHALL have parameter DESYNC_FLAG, default 20, bit index in an address word that requests desync.
REQ-006 SHALL have parameter FRAME_COUNT_WIDTH, default 16, width of FrameCount.
REQ-007 SHALL have ports: CLK  in  1  clock, all logic on rising edge; RST  in  1  asynchronous active-high reset.
REQ-008 SHALL have ports: in_data  in  FRAME_BITS_PER_ROW  config word; in_valid  in  1  word offered; in_ready  out  1  word accepted when in_valid&in_ready.
REQ-009 SHALL have ports: ConfigWriteData  out  FRAME_BITS_PER_ROW  row data; ConfigWriteStrobe  out  1  row write pulse; RowSelect  out  ROW_SELECT_WIDTH  target row, 0 = none.
REQ-010 SHALL have ports: FrameAddressRegister  out  FRAME_BITS_PER_ROW  current frame address; LongFrameStrobe  out  1  frame commit pulse; Synced  out  1  synchronised flag; FrameCount  out  FRAME_COUNT_WIDTH  committed frames.

Function
REQ-011 SHALL implement states IDLE, ADDR, DATA, COMMIT; Synced = 1 in ADDR, DATA, COMMIT.
REQ-012 IDLE: in_ready=1; accepted word equal to SYNC_WORD -> ADDR; any other word discarded, stay IDLE.
REQ-013 ADDR: in_ready=1; accepted word with bit DESYNC_FLAG=1 -> IDLE, FrameAddressRegister unchanged.
REQ-014 ADDR: accepted word with bit DESYNC_FLAG=0 -> FrameAddressRegister=word next cycle, row counter=0, -> DATA.
REQ-015 DATA: in_ready=1; each accepted word registered: next cycle ConfigWriteData=word, RowSelect=row+1, ConfigWriteStrobe=1 for exactly one cycle; row counter increments.
REQ-016 DATA: acceptance of word NUMBER_OF_ROWS -> COMMIT; no word count wrap beyond NUMBER_OF_ROWS.
REQ-017 COMMIT: lasts one cycle, in_ready=0; LongFrameStrobe=1 in the cycle after the last row strobe; FrameCount increments same cycle; -> ADDR.
REQ-018 ConfigWriteStrobe and LongFrameStrobe SHALL never be high in the same cycle.
REQ-019 RowSelect SHALL return to 0 and ConfigWriteStrobe to 0 in any cycle with no row write; ConfigWriteData holds last value.
REQ-020 in_valid=0 cycles SHALL stall the sequence without state change or strobe.
REQ-021 FrameCount SHALL wrap modulo 2^FRAME_COUNT_WIDTH.
REQ-022 SYNC_WORD in DATA SHALL be treated as ordinary data; in ADDR SHALL be treated as an address word.
REQ-023 in_ready SHALL be combinational from state only, never from in_valid.

Reset
REQ-024 RST=1 SHALL immediately force IDLE, in_ready=1 after release, all outputs 0 (FrameCount, FrameAddressRegister, ConfigWriteData, RowSelect, strobes, Synced).
REQ-025 RST mid-frame SHALL abandon the frame with no LongFrameStrobe; partial rows already strobed are not retracted.

Verification
REQ-026 Reset, then 32'h1234_5678, 32'hFAB0_FAB1 -> first ignored, Synced=1 after second, no strobes.
REQ-027 SYNC, address 32'h0000_0003, 16 data words D0..D15 -> 16 strobes RowSelect 1..16 with matching data, then LongFrameStrobe=1 one cycle, FrameAddressRegister=3, FrameCount=1.
REQ-028 Same frame with in_valid toggling every other cycle -> identical strobe sequence, gaps only, no duplicate strobes, in_ready=0 during COMMIT.
REQ-029 In ADDR, word 32'h0010_0000 (bit 20) -> Synced=0 next cycle, FrameAddressRegister unchanged, subsequent data ignored until SYNC.
REQ-030 RST asserted after row 7 strobe -> all outputs 0 asynchronously, no LongFrameStrobe, FrameCount=0; FRAME_COUNT_WIDTH=2 run of 5 frames -> FrameCount=1.

Source files
------------

// File: rtl/config_frame_loader.sv
// config_frame_loader: waits for a sync word, then streams an address word and
// NUMBER_OF_ROWS data words into row write strobes followed by a frame commit pulse.
module config_frame_loader #(
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int NUMBER_OF_ROWS = 16,
    parameter int ROW_SELECT_WIDTH = 5,
    parameter logic [FRAME_BITS_PER_ROW-1:0] SYNC_WORD = 32'hFAB0_FAB1,
    parameter int DESYNC_FLAG = 20,
    parameter int FRAME_COUNT_WIDTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [FRAME_BITS_PER_ROW-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [FRAME_BITS_PER_ROW-1:0] ConfigWriteData,
    output logic                          ConfigWriteStrobe,
    output logic [ROW_SELECT_WIDTH-1:0]   RowSelect,
    output logic [FRAME_BITS_PER_ROW-1:0] FrameAddressRegister,
    output logic                          LongFrameStrobe,
    output logic                          Synced,
    output logic [FRAME_COUNT_WIDTH-1:0]  FrameCount
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, COMMIT} state_t;
    localparam logic [ROW_SELECT_WIDTH-1:0] LAST_ROW = ROW_SELECT_WIDTH'(NUMBER_OF_ROWS - 1);
    state_t r_state, w_next;
    logic [ROW_SELECT_WIDTH-1:0] r_row;
    logic w_acc, w_row_wr, w_addr_wr;
    assign in_ready  = r_state != COMMIT;
    assign Synced    = r_state != IDLE;
    assign w_acc     = in_valid && in_ready;
    assign w_row_wr  = w_acc && r_state == DATA;
    assign w_addr_wr = w_acc && r_state == ADDR && !in_data[DESYNC_FLAG];
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc && in_data == SYNC_WORD) w_next = ADDR;
            ADDR:    if (w_acc) w_next = in_data[DESYNC_FLAG] ? IDLE : DATA;
            DATA:    if (w_acc && r_row == LAST_ROW) w_next = COMMIT;
            default: w_next = ADDR;
        endcase
    end
    // Commit pulse and frame count follow COMMIT by one cycle so they never overlap the last row strobe.
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            r_state              <= IDLE;
            r_row                <= '0;
            ConfigWriteData      <= '0;
            ConfigWriteStrobe    <= 1'b0;
            RowSelect            <= '0;
            FrameAddressRegister <= '0;
            LongFrameStrobe      <= 1'b0;
            FrameCount           <= '0;
        end else begin
            r_state           <= w_next;
            ConfigWriteStrobe <= w_row_wr;
            RowSelect         <= w_row_wr ? r_row + 1'b1 : '0;
            LongFrameStrobe   <= r_state == COMMIT;
            if (w_addr_wr) begin
                FrameAddressRegister <= in_data;
                r_row                <= '0;
            end
            if (w_row_wr) begin
                ConfigWriteData <= in_data;
                r_row           <= r_row + 1'b1;
            end
            if (r_state == COMMIT) FrameCount <= FrameCount + 1'b1;
        end
endmodule

// File: tb/tb_config_frame_loader.sv
// tb_config_frame_loader: scoreboard bench; expected row writes and commits are queued
// as words are driven and matched when the loader emits them.
module tb_config_frame_loader;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, ConfigWriteStrobe, LongFrameStrobe, Synced;
    logic [31:0] ConfigWriteData, FrameAddressRegister;
    logic [4:0]  RowSelect;
    logic [15:0] FrameCount;
    logic        in_ready2, ConfigWriteStrobe2, LongFrameStrobe2, Synced2;
    logic [31:0] ConfigWriteData2, FrameAddressRegister2;
    logic [4:0]  RowSelect2;
    logic [1:0]  FrameCount2;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_fc = '0;
    logic [36:0] exp_q[$];
    logic [47:0] long_q[$];
    logic [36:0] e_row;
    logic [47:0] e_long;
    always #5 CLK = ~CLK;
    config_frame_loader u_dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ConfigWriteData(ConfigWriteData), .ConfigWriteStrobe(ConfigWriteStrobe),
        .RowSelect(RowSelect), .FrameAddressRegister(FrameAddressRegister),
        .LongFrameStrobe(LongFrameStrobe), .Synced(Synced), .FrameCount(FrameCount)
    );
    config_frame_loader #(.FRAME_COUNT_WIDTH(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .ConfigWriteData(ConfigWriteData2), .ConfigWriteStrobe(ConfigWriteStrobe2),
        .RowSelect(RowSelect2), .FrameAddressRegister(FrameAddressRegister2),
        .LongFrameStrobe(LongFrameStrobe2), .Synced(Synced2), .FrameCount(FrameCount2)
    );
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [127:0] all_outs();
        return {40'd0, ConfigWriteData, RowSelect, ConfigWriteStrobe, FrameAddressRegister,
                LongFrameStrobe, Synced, FrameCount};
    endfunction
    always @(negedge CLK) begin
        chk("strobe_overlap", ConfigWriteStrobe & LongFrameStrobe, 0);
        if (ConfigWriteStrobe) begin
            if (exp_q.size() == 0) chk("unexpected_strobe", {RowSelect, ConfigWriteData}, 0);
            else begin
                e_row = exp_q.pop_front();
                chk("row_sel", RowSelect, e_row[36:32]);
                chk("row_data", ConfigWriteData, e_row[31:0]);
                if (e_row[36:32] == 5'd16) chk("ready_in_commit", in_ready, 0);
            end
        end else chk("rowsel_idle", RowSelect, 0);
        if (LongFrameStrobe) begin
            if (long_q.size() == 0) chk("unexpected_long", FrameCount, 0);
            else begin
                e_long = long_q.pop_front();
                chk("long_faddr", FrameAddressRegister, e_long[47:16]);
                chk("long_count", FrameCount, e_long[15:0]);
            end
        end
    end
    task automatic send(input logic [31:0] w, input int gap);
        logic r;
        logic ok;
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = w;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            r = in_ready;
            @(posedge CLK);
            if (r) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        #1 in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask
    task automatic frame(input logic [31:0] addr, input logic [31:0] seed, input int gap, input int rows);
        logic [31:0] k;
        logic [31:0] d;
        send(addr, gap);
        for (int i = 0; i < rows; i++) begin
            k = 32'(i);
            d = seed ^ (k * 32'h0101_0101);
            exp_q.push_back({5'(i + 1), d});
            send(d, gap);
        end
        if (rows == 16) begin
            exp_fc++;
            long_q.push_back({addr, exp_fc});
        end
    endtask
    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_outputs", all_outs(), 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", in_ready, 1);
        send(32'h1234_5678, 0);
        @(negedge CLK);
        chk("junk_ignored", Synced, 0);
        send(SYNC, 0);
        @(negedge CLK);
        chk("synced_after_sync", Synced, 1);
        frame(32'h0000_0003, 32'hA5A5_0000, 0, 16);
        repeat (4) @(negedge CLK);
        chk("faddr_frame1", FrameAddressRegister, 32'h3);
        chk("count_frame1", FrameCount, 1);
        frame(32'h0000_0003, 32'h1357_9BDF, 1, 16);
        repeat (4) @(negedge CLK);
        chk("count_frame2", FrameCount, 2);
        frame(32'h0000_0007, SYNC, 0, 16);
        repeat (4) @(negedge CLK);
        chk("sync_as_data_stays_synced", Synced, 1);
        chk("count_frame3", FrameCount, 3);
        send(32'h0010_0000, 0);
        @(negedge CLK);
        chk("desync_synced", Synced, 0);
        chk("desync_faddr_kept", FrameAddressRegister, 32'h7);
        send(32'h0000_0009, 0);
        send(32'hDEAD_BEEF, 0);
        @(negedge CLK);
        chk("ignored_after_desync", Synced, 0);
        send(SYNC, 0);
        @(negedge CLK);
        chk("resync", Synced, 1);
        frame(32'h0000_0005, 32'h0F0F_0000, 0, 7);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 chk("async_reset_outputs", all_outs(), 0);
        chk("rows_before_reset", exp_q.size(), 0);
        exp_fc = '0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("no_commit_after_reset", FrameCount, 0);
        send(SYNC, 0);
        for (int f = 0; f < 5; f++) frame(32'(f + 1), 32'h2000_0000 + 32'(f << 8), 0, 16);
        repeat (4) @(negedge CLK);
        chk("count_five_frames", FrameCount, 5);
        chk("count_wrap_width2", FrameCount2, 1);
        chk("rows_left", exp_q.size(), 0);
        chk("commits_left", long_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
